// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port dcache arbiter: read-latency default,
// port identifier and the access-kind encoding of the issued operation.
package mem_arb_pkg;

    localparam int unsigned RD_LAT_DEFAULT = 32'd1;

    typedef logic [0:0] port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10
    } acc_kind_t;

    // Classify the access issued this cycle from the grant and the winner's wr bit.
    function automatic acc_kind_t acc_kind_of(input logic granted, input logic wr);
        acc_kind_t kind;
        if (!granted) begin
            kind = ACC_IDLE;
        end else if (wr) begin
            kind = ACC_WRITE;
        end else begin
            kind = ACC_READ;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and dcache-side signals of the arbiter, bundled together.
// slave = the arbiter, master = requesters plus dcache model.
interface mem_port_arbiter_if;

    logic        in_req0;
    logic        in_req1;
    logic        in_wr0;
    logic        in_wr1;
    logic [31:0] in_addr0;
    logic [31:0] in_addr1;
    logic [31:0] in_wdata0;
    logic [31:0] in_wdata1;
    logic        out_gnt0;
    logic        out_gnt1;
    logic        out_rvalid0;
    logic        out_rvalid1;
    logic [31:0] out_rdata0;
    logic [31:0] out_rdata1;
    logic        out_MemWr;
    logic        out_MemRd;
    logic [31:0] out_Wr_data;
    logic [31:0] out_WrRd_addr;
    logic [31:0] in_Rd_data;

    modport slave (
        input  in_req0, in_req1, in_wr0, in_wr1,
        input  in_addr0, in_addr1, in_wdata0, in_wdata1,
        input  in_Rd_data,
        output out_gnt0, out_gnt1, out_rvalid0, out_rvalid1,
        output out_rdata0, out_rdata1,
        output out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr
    );

    modport master (
        output in_req0, in_req1, in_wr0, in_wr1,
        output in_addr0, in_addr1, in_wdata0, in_wdata1,
        output in_Rd_data,
        input  out_gnt0, out_gnt1, out_rvalid0, out_rvalid1,
        input  out_rdata0, out_rdata1,
        input  out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr
    );

endinterface

// File: rtl/mem_arb_tagpipe.sv
// Read-response tag pipeline: each issued read pushes its port ID; the tag
// reaches the last stage in the cycle the dcache presents its data.
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_valid,
    input  port_id_t push_id,
    output logic     pop_valid,
    output port_id_t pop_id
);

    logic     [DEPTH-1:0] vld_q;
    logic     [DEPTH-1:0] vld_d;
    port_id_t [DEPTH-1:0] id_q;
    port_id_t [DEPTH-1:0] id_d;

    // Shift every stage by one; stage 0 takes the newly issued read.
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = push_valid;
        if (push_valid) begin
            id_d[0] = push_id;
        end else begin
            id_d[0] = PORT0;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign pop_valid = vld_q[DEPTH-1];
    assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single dcache port. The grant
// and the dcache access happen in the same cycle; read data is routed back
// to the issuing port one cycle after the dcache returns it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    mem_port_arbiter_if.slave  bus
);

    logic        gnt0_s;
    logic        gnt1_s;
    port_id_t    win_id_s;
    logic        win_wr_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;
    acc_kind_t   kind_s;
    logic        mem_wr_s;
    logic        mem_rd_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    port_id_t    last_q;
    port_id_t    last_d;
    logic        pop_valid_s;
    port_id_t    pop_id_s;
    logic        rvalid0_q;
    logic        rvalid0_d;
    logic        rvalid1_q;
    logic        rvalid1_d;
    logic [31:0] rdata0_q;
    logic [31:0] rdata0_d;
    logic [31:0] rdata1_q;
    logic [31:0] rdata1_d;

    // Grant: a lone requester wins; on contention the port not granted last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!in_rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.in_req0 && bus.in_req1) begin
            if (last_q == PORT1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.in_req0) begin
            gnt0_s = 1'b1;
        end else if (bus.in_req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the winner's request fields.
    always_comb begin
        win_id_s    = PORT0;
        win_wr_s    = bus.in_wr0;
        win_addr_s  = bus.in_addr0;
        win_wdata_s = bus.in_wdata0;
        if (gnt1_s) begin
            win_id_s    = PORT1;
            win_wr_s    = bus.in_wr1;
            win_addr_s  = bus.in_addr1;
            win_wdata_s = bus.in_wdata1;
        end else begin
            win_id_s    = PORT0;
        end
    end

    assign kind_s = acc_kind_of(gnt0_s | gnt1_s, win_wr_s);

    // Drive the dcache strobes; address and data are zero when nothing issues.
    always_comb begin
        mem_wr_s    = 1'b0;
        mem_rd_s    = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (kind_s)
            ACC_WRITE: begin
                mem_wr_s    = 1'b1;
                mem_addr_s  = win_addr_s;
                mem_wdata_s = win_wdata_s;
            end
            ACC_READ: begin
                mem_rd_s    = 1'b1;
                mem_addr_s  = win_addr_s;
            end
            default: begin
                mem_wr_s    = 1'b0;
                mem_rd_s    = 1'b0;
                mem_addr_s  = 32'h0000_0000;
                mem_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Remember the most recent winner for the round-robin decision.
    always_comb begin
        if (gnt0_s || gnt1_s) begin
            last_d = win_id_s;
        end else begin
            last_d = last_q;
        end
    end

    mem_arb_tagpipe #(
        .DEPTH (RD_LAT)
    ) u_tagpipe (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .push_valid (mem_rd_s),
        .push_id    (win_id_s),
        .pop_valid  (pop_valid_s),
        .pop_id     (pop_id_s)
    );

    // Route returning dcache data to the tagged port; the other port holds.
    always_comb begin
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (pop_valid_s && (pop_id_s == PORT0)) begin
            rvalid0_d = 1'b1;
            rdata0_d  = bus.in_Rd_data;
        end else if (pop_valid_s && (pop_id_s == PORT1)) begin
            rvalid1_d = 1'b1;
            rdata1_d  = bus.in_Rd_data;
        end else begin
            rvalid0_d = 1'b0;
            rvalid1_d = 1'b0;
        end
    end

    // State registers; after reset port 1 counts as last winner so port 0 wins first.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            last_q    <= PORT1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'h0000_0000;
            rdata1_q  <= 32'h0000_0000;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.out_gnt0      = gnt0_s;
    assign bus.out_gnt1      = gnt1_s;
    assign bus.out_MemWr     = mem_wr_s;
    assign bus.out_MemRd     = mem_rd_s;
    assign bus.out_WrRd_addr = mem_addr_s;
    assign bus.out_Wr_data   = mem_wdata_s;
    assign bus.out_rvalid0   = rvalid0_q;
    assign bus.out_rvalid1   = rvalid1_q;
    assign bus.out_rdata0    = rdata0_q;
    assign bus.out_rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3, driven from a single linear stimulus sequence.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] e1_d0 = 32'h0;
    logic [31:0] e1_d1 = 32'h0;
    logic [31:0] e3_d0 = 32'h0;
    logic [31:0] e3_d1 = 32'h0;

    logic [31:0] rr_data [4] = '{32'h0000_00A0, 32'h0000_00B1, 32'h0000_00A2, 32'h0000_00B3};
    int          l3_port [4] = '{0, 1, 1, 0};

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.RD_LAT(1)) u_dut1 (.in_clk(clk), .in_rst_n(rst_n), .bus(b1));
    mem_port_arbiter #(.RD_LAT(3)) u_dut3 (.in_clk(clk), .in_rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b1.in_req0 = 1'b0; b1.in_req1 = 1'b0; b1.in_wr0 = 1'b0; b1.in_wr1 = 1'b0;
        b1.in_addr0 = 32'h0; b1.in_addr1 = 32'h0; b1.in_wdata0 = 32'h0; b1.in_wdata1 = 32'h0;
        b1.in_Rd_data = 32'h0;
        b3.in_req0 = 1'b0; b3.in_req1 = 1'b0; b3.in_wr0 = 1'b0; b3.in_wr1 = 1'b0;
        b3.in_addr0 = 32'h0; b3.in_addr1 = 32'h0; b3.in_wdata0 = 32'h0; b3.in_wdata1 = 32'h0;
        b3.in_Rd_data = 32'h0;
    endtask

    task automatic chk_iss1(input string tag, input logic g0, input logic g1, input logic wr,
                            input logic rd, input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, "_gnt0"},  {31'd0, b1.out_gnt0},  {31'd0, g0});
        chk({tag, "_gnt1"},  {31'd0, b1.out_gnt1},  {31'd0, g1});
        chk({tag, "_memwr"}, {31'd0, b1.out_MemWr}, {31'd0, wr});
        chk({tag, "_memrd"}, {31'd0, b1.out_MemRd}, {31'd0, rd});
        chk({tag, "_addr"},  b1.out_WrRd_addr, addr);
        chk({tag, "_wdata"}, b1.out_Wr_data,   wdata);
    endtask

    task automatic chk_iss3(input string tag, input logic g0, input logic g1, input logic wr,
                            input logic rd, input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, "_gnt0"},  {31'd0, b3.out_gnt0},  {31'd0, g0});
        chk({tag, "_gnt1"},  {31'd0, b3.out_gnt1},  {31'd0, g1});
        chk({tag, "_memwr"}, {31'd0, b3.out_MemWr}, {31'd0, wr});
        chk({tag, "_memrd"}, {31'd0, b3.out_MemRd}, {31'd0, rd});
        chk({tag, "_addr"},  b3.out_WrRd_addr, addr);
        chk({tag, "_wdata"}, b3.out_Wr_data,   wdata);
    endtask

    task automatic chk_resp1(input string tag, input logic v0, input logic v1);
        chk({tag, "_rvalid0"}, {31'd0, b1.out_rvalid0}, {31'd0, v0});
        chk({tag, "_rvalid1"}, {31'd0, b1.out_rvalid1}, {31'd0, v1});
        chk({tag, "_rdata0"},  b1.out_rdata0, e1_d0);
        chk({tag, "_rdata1"},  b1.out_rdata1, e1_d1);
    endtask

    task automatic chk_resp3(input string tag, input logic v0, input logic v1);
        chk({tag, "_rvalid0"}, {31'd0, b3.out_rvalid0}, {31'd0, v0});
        chk({tag, "_rvalid1"}, {31'd0, b3.out_rvalid1}, {31'd0, v1});
        chk({tag, "_rdata0"},  b3.out_rdata0, e3_d0);
        chk({tag, "_rdata1"},  b3.out_rdata1, e3_d1);
    endtask

    initial begin
        idle_all();

        // During reset: requests present, but no grant or strobe; responses cleared.
        #2;
        b1.in_req0 = 1'b1; b1.in_addr0 = 32'h0000_0010;
        b3.in_req1 = 1'b1; b3.in_addr1 = 32'h0000_0020;
        #1;
        chk_iss1("rst_gate1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_iss3("rst_gate3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_resp1("rst_resp1", 1'b0, 1'b0);
        chk_resp3("rst_resp3", 1'b0, 1'b0);
        idle_all();
        step();
        rst_n = 1'b1;
        step();

        // Both ports read continuously for 4 cycles: grants 0,1,0,1, responses in order.
        b1.in_addr0 = 32'h0000_0100;
        b1.in_addr1 = 32'h0000_0200;
        for (int k = 0; k < 7; k++) begin
            b1.in_req0 = (k < 4);
            b1.in_req1 = (k < 4);
            b1.in_Rd_data = (k >= 1 && k <= 4) ? rr_data[k-1] : 32'h0;
            #1;
            if (k < 4) begin
                if ((k % 2) == 0) chk_iss1("rr_iss", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
                else              chk_iss1("rr_iss", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
            end else begin
                chk_iss1("rr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (k >= 2 && k <= 5) begin
                if (((k - 2) % 2) == 0) begin
                    e1_d0 = rr_data[k-2];
                    chk_resp1("rr_resp", 1'b1, 1'b0);
                end else begin
                    e1_d1 = rr_data[k-2];
                    chk_resp1("rr_resp", 1'b0, 1'b1);
                end
            end else begin
                chk_resp1("rr_noresp", 1'b0, 1'b0);
            end
            step();
        end

        // Single port 0 read of 0x10, dcache returns 0xDEADBEEF.
        b1.in_req0 = 1'b1; b1.in_wr0 = 1'b0; b1.in_addr0 = 32'h0000_0010;
        #1;
        chk_iss1("rd0_iss", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        chk_resp1("rd0_c0", 1'b0, 1'b0);
        step();
        b1.in_req0 = 1'b0; b1.in_Rd_data = 32'hDEAD_BEEF;
        #1;
        chk_iss1("rd0_c1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_resp1("rd0_c1", 1'b0, 1'b0);
        step();
        b1.in_Rd_data = 32'h0;
        #1;
        e1_d0 = 32'hDEAD_BEEF;
        chk_resp1("rd0_c2", 1'b1, 1'b0);
        step();
        #1;
        chk_resp1("rd0_hold", 1'b0, 1'b0);

        // Port 0 write vs port 1 read with port 0 last: read first, write next cycle.
        b1.in_req0 = 1'b1; b1.in_wr0 = 1'b1; b1.in_addr0 = 32'h0000_0080; b1.in_wdata0 = 32'hCAFE_F00D;
        b1.in_req1 = 1'b1; b1.in_wr1 = 1'b0; b1.in_addr1 = 32'h0000_0044;
        #1;
        chk_iss1("mix_c0", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0);
        step();
        b1.in_req1 = 1'b0; b1.in_Rd_data = 32'h5555_AAAA;
        #1;
        chk_iss1("mix_c1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D);
        chk_resp1("mix_c1", 1'b0, 1'b0);
        step();
        b1.in_req0 = 1'b0; b1.in_wr0 = 1'b0; b1.in_Rd_data = 32'h0;
        #1;
        e1_d1 = 32'h5555_AAAA;
        chk_resp1("mix_c2", 1'b0, 1'b1);
        step();
        #1;
        chk_resp1("mix_c3", 1'b0, 1'b0);

        // Port 1 write of 0x12345678 to 0x40 while port 0 idle: no response.
        b1.in_req1 = 1'b1; b1.in_wr1 = 1'b1; b1.in_addr1 = 32'h0000_0040; b1.in_wdata1 = 32'h1234_5678;
        #1;
        chk_iss1("wr1_c0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
        step();
        b1.in_req1 = 1'b0; b1.in_wr1 = 1'b0;
        #1;
        chk_iss1("wr1_c1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_resp1("wr1_c1", 1'b0, 1'b0);
        step();
        #1;
        chk_resp1("wr1_c2", 1'b0, 1'b0);

        // Read issued, reset the next cycle: the read is discarded and rdata cleared.
        b1.in_req0 = 1'b1; b1.in_addr0 = 32'h0000_0020;
        #1;
        chk_iss1("rstmid_iss", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        step();
        b1.in_req0 = 1'b0; b1.in_Rd_data = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        e1_d0 = 32'h0;
        e1_d1 = 32'h0;
        chk_resp1("rstmid_in", 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        b1.in_Rd_data = 32'h0;
        #1;
        chk_resp1("rstmid_rel", 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk_resp1("rstmid_after", 1'b0, 1'b0);
        end
        step();

        // RD_LAT=3: four back-to-back reads (ports 0,1,1,0) returning 1,2,3,4.
        for (int k = 0; k < 9; k++) begin
            b3.in_req0 = (k < 4) && (l3_port[k % 4] == 0);
            b3.in_req1 = (k < 4) && (l3_port[k % 4] == 1);
            b3.in_addr0 = 32'h0000_0300 + 32'(4 * k);
            b3.in_addr1 = 32'h0000_0300 + 32'(4 * k);
            b3.in_Rd_data = (k >= 3 && k <= 6) ? 32'(k - 2) : 32'h0;
            #1;
            if (k < 4) begin
                if (l3_port[k] == 0)
                    chk_iss3("lat3_iss", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300 + 32'(4 * k), 32'h0);
                else
                    chk_iss3("lat3_iss", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300 + 32'(4 * k), 32'h0);
            end else begin
                chk_iss3("lat3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (k >= 4 && k <= 7) begin
                if (l3_port[k-4] == 0) begin
                    e3_d0 = 32'(k - 3);
                    chk_resp3("lat3_resp", 1'b1, 1'b0);
                end else begin
                    e3_d1 = 32'(k - 3);
                    chk_resp3("lat3_resp", 1'b0, 1'b1);
                end
            end else begin
                chk_resp3("lat3_noresp", 1'b0, 1'b0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
